// File: rtl/c_result_reader_if.sv
// rtl/c_result_reader_if.sv - result write, read-request and response stream bundle for c_result_reader
interface c_result_reader_if #(
   parameter int DEPTH = 4
);
   logic [15:0]      C_index;
   logic [127:0]     C_data_in;
   logic             C_wr_en;
   logic             clear;
   logic             req_valid;
   logic             req_ready;
   logic [7:0]       req_row;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic             rsp_last;
   logic             rsp_err;
   logic [DEPTH-1:0] rows_valid;

   modport master (
      output C_index, C_data_in, C_wr_en, clear, req_valid, req_row, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, rows_valid
   );

   modport slave (
      input  C_index, C_data_in, C_wr_en, clear, req_valid, req_row, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, rows_valid
   );
endinterface

// File: rtl/c_result_reader.sv
// rtl/c_result_reader.sv - stores systolic-array result rows and streams a requested row as four 32-bit words
module c_result_reader #(
   parameter int DEPTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   c_result_reader_if.slave  bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_STREAM = 2'd2
   } state_t;

   state_t           state, next_state;
   logic [127:0]     mem [DEPTH];
   logic [DEPTH-1:0] rows_valid_q;
   logic [AW-1:0]    row_q;
   logic             err_q;
   logic [127:0]     shadow_q;
   logic [1:0]       widx_q;

   logic             wr_hit;
   logic [AW-1:0]    wr_row;
   logic [DEPTH-1:0] wr_onehot;
   logic             req_in_range;
   logic [AW-1:0]    req_row_idx;
   logic             accept;
   logic             enter_stream;
   logic [AW-1:0]    snap_row;
   logic [127:0]     snap_data;

   logic             req_ready_c;
   logic             rsp_valid_c;
   logic [31:0]      rsp_data_c;
   logic             rsp_last_c;
   logic             rsp_err_c;

   assign wr_hit       = bus.C_wr_en && ({1'b0, bus.C_index} < 17'(DEPTH));
   assign wr_row       = bus.C_index[AW-1:0];
   assign wr_onehot    = wr_hit ? (DEPTH'(1) << wr_row) : '0;
   assign req_in_range = ({1'b0, bus.req_row} < 9'(DEPTH));
   assign req_row_idx  = bus.req_row[AW-1:0];
   assign accept       = bus.req_valid && (state == S_IDLE);
   assign enter_stream = (next_state == S_STREAM) && (state != S_STREAM);

   // The snapshot row is the incoming request when leaving IDLE, else the latched one;
   // a same-cycle write to that row is forwarded so the stream never sees stale data.
   assign snap_row  = (state == S_IDLE) ? req_row_idx : row_q;
   assign snap_data = (wr_hit && (wr_row == snap_row)) ? bus.C_data_in : mem[snap_row];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      req_ready_c = 1'b0;
      rsp_valid_c = 1'b0;
      rsp_data_c  = 32'd0;
      rsp_last_c  = 1'b0;
      rsp_err_c   = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready_c = 1'b1;
            if (bus.req_valid) begin
               if (!req_in_range) begin
                  next_state = S_STREAM;
               end else if (rows_valid_q[req_row_idx]) begin
                  next_state = S_STREAM;
               end else begin
                  next_state = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (rows_valid_q[row_q]) begin
               next_state = S_STREAM;
            end
         end
         S_STREAM: begin
            rsp_valid_c = 1'b1;
            rsp_data_c  = err_q ? 32'd0 : shadow_q[{widx_q, 5'd0} +: 32];
            rsp_last_c  = (widx_q == 2'd3);
            rsp_err_c   = err_q;
            if (bus.rsp_ready && (widx_q == 2'd3)) begin
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Row storage deliberately survives reset; only the valid flags are cleared.
   always_ff @(posedge clk) begin
      if (wr_hit) begin
         mem[wr_row] <= bus.C_data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rows_valid_q <= '0;
      end else begin
         rows_valid_q <= (bus.clear ? '0 : rows_valid_q) | wr_onehot;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_q    <= '0;
         err_q    <= 1'b0;
         shadow_q <= '0;
         widx_q   <= 2'd0;
      end else begin
         if (accept) begin
            row_q <= req_row_idx;
            err_q <= !req_in_range;
         end
         if (enter_stream) begin
            shadow_q <= snap_data;
            widx_q   <= 2'd0;
         end else if ((state == S_STREAM) && bus.rsp_ready) begin
            widx_q <= widx_q + 2'd1;
         end
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.rsp_valid  = rsp_valid_c;
   assign bus.rsp_data   = rsp_data_c;
   assign bus.rsp_last   = rsp_last_c;
   assign bus.rsp_err    = rsp_err_c;
   assign bus.rows_valid = rows_valid_q;
endmodule
